// File: rtl/seq_scan_ctrl.sv
// Word-level wrapper around an overlapping "1101" Moore detector: accepts a
// word, scans it MSB-first one bit per clock, then returns match count and first-hit index.
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cont,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [POS_W-1:0] out_first
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_t;

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);

  ctrl_t            state_reg, state_next;
  det_t             det_reg, det_next, det_step;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [POS_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [POS_W-1:0] first_reg, first_next;
  logic             hit_reg, hit_next;
  logic             scan_bit;

  assign scan_bit  = shift_reg[WIDTH-1];
  // Gated by rst so the producer never sees ready while reset is held.
  assign in_ready  = (state_reg == IDLE) && rst;
  assign out_valid = (state_reg == DONE);
  assign out_count = count_reg;
  assign out_first = first_reg;

  always_comb begin
    det_step = S0;
    case (det_reg)
      S0:      det_step = scan_bit ? S1 : S0;
      S1:      det_step = scan_bit ? S2 : S0;
      S2:      det_step = scan_bit ? S2 : S3;
      S3:      det_step = scan_bit ? S4 : S0;
      S4:      det_step = scan_bit ? S2 : S0;
      default: det_step = S0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    first_next = first_reg;
    hit_next   = hit_reg;
    // Detector state is held between words; an illegal encoding falls back to S0.
    case (det_reg)
      S0, S1, S2, S3, S4: det_next = det_reg;
      default:            det_next = S0;
    endcase

    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_next = SHIFT;
          shift_next = in_data;
          idx_next   = '0;
          count_next = '0;
          first_next = '0;
          hit_next   = 1'b0;
          if (!in_cont) det_next = S0;
        end
      end
      SHIFT: begin
        det_next   = det_step;
        shift_next = {shift_reg[WIDTH-2:0], 1'b0};
        idx_next   = idx_reg + 1'b1;
        if (det_step == S4) begin
          count_next = count_reg + 1'b1;
          if (!hit_reg) begin
            first_next = idx_reg;
            hit_next   = 1'b1;
          end
        end
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      det_reg   <= S0;
      shift_reg <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
      first_reg <= '0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      det_reg   <= det_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
      first_reg <= first_next;
      hit_reg   <= hit_next;
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: table of words with expected results fed through a
// scoreboard queue, plus hand sequences for backpressure and mid-word reset.
module tb_seq_scan_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int POS_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_cont = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_count;
  logic [POS_W-1:0] out_first;

  seq_scan_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cont(in_cont),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_first(out_first)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         cont;
    int         cnt;
    int         first;
  } vec_t;

  typedef struct {
    int cnt;
    int first;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   word_no = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present the word for one accept edge.
  task automatic accept_word(input logic [7:0] data, input bit cont);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = data;
    in_cont  = cont;
    tick();
    in_valid = 1'b0;
    in_cont  = 1'b0;
    check("in_ready_busy", int'(in_ready), 0);
  endtask

  // Counts edges after the accept until out_valid rises; must equal WIDTH.
  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", n, WIDTH);
  endtask

  task automatic take_result();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check("out_valid", int'(out_valid), 1);
    check("out_count", int'(out_count), e.cnt);
    check("out_first", int'(out_first), e.first);
    $display("word %0d: count=%0d first=%0d (exp %0d/%0d)",
             word_no, out_count, out_first, e.cnt, e.first);
    word_no++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after_hs", int'(in_ready), 1);
    check("out_valid_after_hs", int'(out_valid), 0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'hD0, 1'b0, 1, 3};
    vecs[1] = '{8'hDA, 1'b0, 2, 3};
    vecs[2] = '{8'h00, 1'b0, 0, 0};
    vecs[3] = '{8'hFF, 1'b0, 0, 0};
    vecs[4] = '{8'h03, 1'b0, 0, 0};
    vecs[5] = '{8'h40, 1'b1, 1, 1};
    vecs[6] = '{8'h03, 1'b0, 0, 0};
    vecs[7] = '{8'h40, 1'b0, 0, 0};
    vecs[8] = '{8'hB6, 1'b0, 1, 5};
    vecs[9] = '{8'h6D, 1'b0, 2, 4};

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_out_first", int'(out_first), 0);
    rst = 1'b1;
    #1;
    check("rst_release_in_ready", int'(in_ready), 1);
    tick();

    for (int i = 0; i < 10; i++) begin
      sb_q.push_back('{vecs[i].cnt, vecs[i].first});
      accept_word(vecs[i].data, vecs[i].cont);
      wait_result();
      take_result();
    end

    // Backpressure: result held for 5 cycles, in_valid ignored meanwhile
    sb_q.push_back('{1, 3});
    accept_word(8'hD0, 1'b0);
    wait_result();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_count", int'(out_count), 1);
      check("bp_out_first", int'(out_first), 3);
      check("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    take_result();
    // Back-to-back: in_ready is already 1, accept on the very next edge
    sb_q.push_back('{2, 3});
    accept_word(8'hDA, 1'b0);
    wait_result();
    take_result();

    // Reset during the 4th bit cycle aborts the word
    accept_word(8'hD0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_count", int'(out_count), 0);
    check("midrst_out_first", int'(out_first), 0);
    rst = 1'b1;
    #1;
    check("midrst_release_in_ready", int'(in_ready), 1);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) check("midrst_no_result", int'(out_valid), 0);
    end
    sb_q.push_back('{1, 3});
    accept_word(8'hD0, 1'b1);
    wait_result();
    take_result();

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
